// File: rtl/video_pkg.sv
// Shared video timing constants and the CPU arbiter state type used by the
// VRAM arbiter and the video controller.
package video_pkg;

  // CPU port states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } arb_state_t;

  // Memory ticks per cell spent issuing video addresses (2 words x 2 bytes)
  localparam int VID_TICKS       = 4;
  // ce_24m ticks per 8-pixel cell
  localparam int CELL_TICKS      = 32;

  // Pixel-cell timing shared with the video controller
  localparam int CELL_PIXELS     = 8;
  localparam int TICKS_PER_PIXEL = CELL_TICKS / CELL_PIXELS;
  // Pixel within the cell on which the controller latches vid_dout1/2
  localparam int VID_LATCH_PIXEL = 4;

endpackage

// File: rtl/vram_cpu_port.sv
// CPU side of the VRAM arbiter: single outstanding byte read/write with a
// one-cycle ack. The top level decides which ticks the bus is free.
module vram_cpu_port
  import video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       bus_free_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] mem_din_i,
  output logic       issue_o,
  output logic [7:0] dout_o,
  output logic       ack_o
);

  arb_state_t state_q, state_d;
  logic [7:0] dout_q, dout_d;

  // Next-state and handshake decode; ack lasts exactly the one DONE cycle
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    issue_o = 1'b0;
    ack_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_i && bus_free_i && req_i) begin
          issue_o = 1'b1;
          state_d = we_i ? DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        // SRAM data for the address issued on the previous tick
        if (ce_i) begin
          dout_d  = mem_din_i;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and read-data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/vram_arbiter.sv
// Time-multiplexes one 8-bit SRAM between the per-cell video fetch (ticks
// 0..3 issue, 1..4 capture) and single CPU byte accesses on the other ticks.
// CPU_FIRST_TICK must not be below VID_TICKS.
module vram_arbiter
  import video_pkg::*;
#(
  parameter int AW             = 19,
  parameter int CPU_FIRST_TICK = 4,
  parameter int CELL_TICKS     = 32
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_24m,
  input  logic          vid_strobe,
  input  logic          vid_active,
  input  logic [AW-1:0] vid_addr1,
  input  logic [AW-1:0] vid_addr2,
  output logic [15:0]   vid_dout1,
  output logic [15:0]   vid_dout2,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dout,
  input  logic [7:0]    mem_din,
  output logic          mem_we
);

  localparam logic [4:0] TK_LAST = 5'(CELL_TICKS - 1);
  localparam logic [4:0] TK_CPU  = 5'(CPU_FIRST_TICK);
  localparam logic [4:0] TK_VID  = 5'(VID_TICKS);

  logic [4:0]    tk_q, tk_d, tick_now;
  logic          vfetch_q, vfetch_d, vfetch_now;
  logic          vid_issue, bus_free, cpu_issue;
  logic [AW-1:0] vid_addr_now;
  logic [7:0]    st1_lo_q, st1_lo_d, st1_hi_q, st1_hi_d, st2_lo_q, st2_lo_d;
  logic [15:0]   vid1_q, vid1_d, vid2_q, vid2_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_dout_q, mem_dout_d;
  logic          mem_we_q, mem_we_d;

  // A strobe cycle is tick 0 of the new cell, even when it carries a ce_24m
  always_comb begin
    tick_now   = vid_strobe ? 5'd0 : tk_q;
    vfetch_now = vid_strobe ? vid_active : vfetch_q;
    vid_issue  = vfetch_now && (tick_now < TK_VID);
    bus_free   = !(vfetch_now && (tick_now < TK_CPU));
  end

  // Video byte address for ticks 0..3: addr1, addr1+1, addr2, addr2+1
  always_comb begin
    vid_addr_now = vid_addr1;
    unique case (tick_now[1:0])
      2'd0: vid_addr_now = vid_addr1;
      2'd1: vid_addr_now = vid_addr1 + AW'(1);
      2'd2: vid_addr_now = vid_addr2;
      2'd3: vid_addr_now = vid_addr2 + AW'(1);
      default: vid_addr_now = vid_addr1;
    endcase
  end

  vram_cpu_port u_cpu_port (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .ce_i       (ce_24m),
    .bus_free_i (bus_free),
    .req_i      (cpu_req),
    .we_i       (cpu_we),
    .mem_din_i  (mem_din),
    .issue_o    (cpu_issue),
    .dout_o     (cpu_dout),
    .ack_o      (cpu_ack)
  );

  // Tick counter, bus driver and video capture; everything moves on ce_24m
  always_comb begin
    tk_d       = tk_q;
    vfetch_d   = vfetch_q;
    st1_lo_d   = st1_lo_q;
    st1_hi_d   = st1_hi_q;
    st2_lo_d   = st2_lo_q;
    vid1_d     = vid1_q;
    vid2_d     = vid2_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    mem_we_d   = mem_we_q;
    if (vid_strobe) begin
      tk_d     = 5'd0;
      vfetch_d = vid_active;
    end
    if (ce_24m) begin
      tk_d     = (tick_now == TK_LAST) ? 5'd0 : tick_now + 5'd1;
      mem_we_d = 1'b0;
      // Video owns the bus on its issue ticks; the CPU only sees bus_free
      if (vid_issue) begin
        mem_addr_d = vid_addr_now;
      end else if (cpu_issue) begin
        mem_addr_d = cpu_addr;
        if (cpu_we) begin
          mem_dout_d = cpu_din;
          mem_we_d   = 1'b1;
        end
      end
      // Bytes return one tick after their address: ticks 1..4
      if (vfetch_now) begin
        unique case (tick_now)
          5'd1: st1_lo_d = mem_din;
          5'd2: st1_hi_d = mem_din;
          5'd3: st2_lo_d = mem_din;
          5'd4: begin
            vid1_d = {st1_hi_q, st1_lo_q};
            vid2_d = {mem_din, st2_lo_q};
          end
          default: ;
        endcase
      end
    end
  end

  // State registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tk_q       <= '0;
      vfetch_q   <= 1'b0;
      st1_lo_q   <= '0;
      st1_hi_q   <= '0;
      st2_lo_q   <= '0;
      vid1_q     <= '0;
      vid2_q     <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      tk_q       <= tk_d;
      vfetch_q   <= vfetch_d;
      st1_lo_q   <= st1_lo_d;
      st1_hi_q   <= st1_hi_d;
      st2_lo_q   <= st2_lo_d;
      vid1_q     <= vid1_d;
      vid2_q     <= vid2_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign vid_dout1 = vid1_q;
  assign vid_dout2 = vid2_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dout  = mem_dout_q;
  assign mem_we    = mem_we_q;

endmodule
